// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a doubleword-wide data memory (RV64 B/H/W/D).
// Optional: define LSU_MISALIGN_FAULT_EN to fault on accesses not aligned to their size.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 8192,
    parameter int unsigned XLEN      = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    input  logic            req_store_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            busy_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic            mem_write_o,
    output logic            mem_read_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            done_o,
    output logic            fault_o,
    output logic [XLEN-1:0] load_data_o
);
    localparam int unsigned SH_W = 6;

    typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, FAULT} state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d, rd_q, rd_d, wr_q, wr_d, done_q, done_d, fault_q, fault_d;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   addr_q, wdata_q, old_q, load_data_q;
    logic              req_fault;
    logic [SH_W-1:0]   lane_sh;
    logic [XLEN-1:0]   lane, ext, mask, merged;

    // Request legality, evaluated on the raw inputs at accept time
    always_comb begin
        req_fault = (req_addr_i >= XLEN'(MEM_BYTES));
        if (req_store_i) req_fault = req_fault | req_funct3_i[2];
        else             req_fault = req_fault | (req_funct3_i == 3'b111);
`ifdef LSU_MISALIGN_FAULT_EN
        case (req_funct3_i[1:0])
            2'b01:   req_fault = req_fault | req_addr_i[0];
            2'b10:   req_fault = req_fault | (req_addr_i[1:0] != 2'b00);
            2'b11:   req_fault = req_fault | (req_addr_i[2:0] != 3'b000);
            default: ;
        endcase
`endif
    end

    // Lane extraction straight from the bus so the result registers on the READ->RESP edge;
    // bytes shifted past bit 63 come back as zero.
    always_comb begin
        lane_sh = {addr_q[2:0], 3'b000};
        lane    = mem_rdata_i >> lane_sh;
        case (funct3_q)
            3'b000:  ext = {{56{lane[7]}},  lane[7:0]};
            3'b001:  ext = {{48{lane[15]}}, lane[15:0]};
            3'b010:  ext = {{32{lane[31]}}, lane[31:0]};
            3'b100:  ext = {56'd0, lane[7:0]};
            3'b101:  ext = {48'd0, lane[15:0]};
            3'b110:  ext = {32'd0, lane[31:0]};
            default: ext = mem_rdata_i;
        endcase
    end

    // Sub-word store merge into the previously read doubleword
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   mask = XLEN'(8'hFF) << lane_sh;
            2'b01:   mask = XLEN'(16'hFFFF) << lane_sh;
            2'b10:   mask = XLEN'(32'hFFFF_FFFF) << lane_sh;
            default: mask = '1;
        endcase
        if (funct3_q[1:0] == 2'b11) merged = wdata_q;
        else                        merged = (old_q & ~mask) | ((wdata_q << lane_sh) & mask);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_fault)                                        state_d = FAULT;
                    else if (req_store_i && (req_funct3_i[1:0] == 2'b11)) state_d = WRITE;
                    else                                                  state_d = READ;
                end
            end
            READ:    state_d = store_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        rd_d    = (state_d == READ);
        wr_d    = (state_d == WRITE);
        done_d  = (state_d == RESP) || (state_d == FAULT);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            old_q       <= '0;
            load_data_q <= '0;
        end else begin
            if ((state_q == IDLE) && req_valid_i) begin
                store_q  <= req_store_i;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
            end
            if (state_q == READ) old_q <= mem_rdata_i;
            if (done_d) load_data_q <= ((state_q == READ) && !store_q) ? ext : '0;
        end
    end

    assign busy_o      = busy_q;
    assign mem_read_o  = rd_q;
    assign mem_write_o = wr_q;
    assign done_o      = done_q;
    assign fault_o     = fault_q;
    assign load_data_o = load_data_q;
    assign mem_addr_o  = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wdata_o = merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference memory predicts every response.
module tb_load_store_unit;
    localparam int unsigned MEM_BYTES = 8192;
    localparam int unsigned WORDS     = MEM_BYTES / 8;

    typedef struct {
        logic        fault;
        logic [63:0] data;
        int          lat;
        int          writes;
        int          reads;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        busy, mem_write, mem_read, done, fault;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, load_data;

    logic [63:0] mem     [WORDS];
    logic [63:0] ref_mem [WORDS];
    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;
    int          obs_lat, obs_writes, obs_reads;
    logic        obs_done, obs_fault, obs_overlap;
    logic [63:0] obs_data;

    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? mem[mem_addr[12:3]] : 64'h0;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_store_i(req_store), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .busy_o(busy), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_write_o(mem_write), .mem_read_o(mem_read), .mem_rdata_i(mem_rdata),
        .done_o(done), .fault_o(fault), .load_data_o(load_data)
    );

    // Reference: byte-by-byte access semantics, updates ref_mem for stores
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [63:0] a,
                                   input logic [63:0] wd);
        exp_t e;
        int idx, off, sz;
        logic [63:0] w, v;
        e.fault = (a >= 64'(MEM_BYTES)) || (st ? f3[2] : (f3 == 3'b111));
`ifdef LSU_MISALIGN_FAULT_EN
        if ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00) ||
            (f3[1:0] == 2'b11 && a[2:0] != 3'b000)) e.fault = 1'b1;
`endif
        e.data = '0; e.lat = 1; e.writes = 0; e.reads = 0;
        if (e.fault) return e;
        idx = int'(a[12:3]); off = int'(a[2:0]); sz = 1 << f3[1:0];
        w = ref_mem[idx];
        if (st) begin
            e.writes = 1;
            if (f3[1:0] == 2'b11) begin
                w = wd; e.lat = 2;
            end else begin
                for (int i = 0; i < sz; i++) if (off + i < 8) w[(off+i)*8 +: 8] = wd[i*8 +: 8];
                e.lat = 3; e.reads = 1;
            end
            ref_mem[idx] = w;
        end else begin
            e.lat = 2; e.reads = 1; v = '0;
            if (f3[1:0] == 2'b11) v = w;
            else begin
                for (int i = 0; i < sz; i++) if (off + i < 8) v[i*8 +: 8] = w[(off+i)*8 +: 8];
                if (!f3[2] && v[sz*8-1]) for (int i = sz*8; i < 64; i++) v[i] = 1'b1;
            end
            e.data = v;
        end
        return e;
    endfunction

    // Issue one request once IDLE, push its prediction, follow it to done while acting as memory
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin @(negedge clk); guard++; end
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        sb.push_back(model(st, f3, a, wd));
        @(posedge clk); #1;
        req_valid = 1'b0;
        obs_lat = 1; obs_writes = 0; obs_reads = 0; obs_overlap = 1'b0;
        while (!done && obs_lat < 20) begin
            if (mem_write) begin mem[mem_addr[12:3]] = mem_wdata; obs_writes++; end
            if (mem_read) obs_reads++;
            if (mem_read && mem_write) obs_overlap = 1'b1;
            @(posedge clk); #1;
            obs_lat++;
        end
        obs_done = done; obs_fault = fault; obs_data = load_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, mem_write, mem_read, done, fault, load_data, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%0b wr=%0b rd=%0b done=%0b fault=%0b ld=%h addr=%h wdata=%h, want all 0",
                     busy, mem_write, mem_read, done, fault, load_data, mem_addr, mem_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3};
        logic [63:0] ads [7] = '{64'h17, 64'h17, 64'h16, 64'h16, 64'h14, 64'h14, 64'h10};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            run_req(1'b0, f3s[i], ads[i], 64'h0);
            e = sb.pop_front();
            n_chk++;
            if ({obs_done, obs_fault, obs_lat} !== {1'b1, e.fault, e.lat}) begin
                n_fail++;
                $display("FAIL load%0d timing: done=%0b fault=%0b lat=%0d, want 1 %0b %0d", i, obs_done, obs_fault, obs_lat, e.fault, e.lat);
            end
            n_chk++;
            if ({obs_data, obs_writes, obs_reads, obs_overlap} !== {e.data, e.writes, e.reads, 1'b0}) begin
                n_fail++;
                $display("FAIL load%0d result: data=%h wr=%0d rd=%0d ovl=%0b, want %h %0d %0d 0", i, obs_data, obs_writes, obs_reads, obs_overlap, e.data, e.writes, e.reads);
            end
            if (i < 2) begin
                n_chk++;
                if (obs_data !== ((i == 0) ? 64'hFFFF_FFFF_FFFF_FF88 : 64'h88)) begin
                    n_fail++;
                    $display("FAIL lb_lbu_0x17 op%0d: data=%h", i, obs_data);
                end
            end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3s [4] = '{3'd1, 3'd0, 3'd2, 3'd3};
        logic [63:0] ads [4] = '{64'h12, 64'h18, 64'h1C, 64'h20};
        logic [63:0] wds [4] = '{64'hBEEF, 64'h11AB, 64'h5555_DEAD_BEEF, 64'hCAFE_F00D_1234_5678};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_req(1'b1, f3s[i], ads[i], wds[i]);
            e = sb.pop_front();
            n_chk++;
            if ({obs_done, obs_fault, obs_lat} !== {1'b1, e.fault, e.lat}) begin
                n_fail++;
                $display("FAIL store%0d timing: done=%0b fault=%0b lat=%0d, want 1 %0b %0d", i, obs_done, obs_fault, obs_lat, e.fault, e.lat);
            end
            n_chk++;
            if ({obs_data, obs_writes, obs_reads, obs_overlap, mem[ads[i][12:3]]} !==
                {64'h0, e.writes, e.reads, 1'b0, ref_mem[ads[i][12:3]]}) begin
                n_fail++;
                $display("FAIL store%0d result: ld=%h wr=%0d rd=%0d ovl=%0b word=%h, want 0 %0d %0d 0 %h", i, obs_data, obs_writes, obs_reads, obs_overlap, mem[ads[i][12:3]], e.writes, e.reads, ref_mem[ads[i][12:3]]);
            end
        end
        n_chk++;
        if (mem[2] !== 64'h8877_6655_BEEF_2211) begin
            n_fail++;
            $display("FAIL sh_0x12_word: word=%h, want 88776655beef2211", mem[2]);
        end
    endtask

    task automatic test_sd_boundary();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            run_req(i == 0, 3'd3, 64'h1FF8, 64'h0123_4567_89AB_CDEF);
            e = sb.pop_front();
            n_chk++;
            if ({obs_done, obs_fault, obs_lat, obs_writes, obs_reads} !== {1'b1, e.fault, e.lat, e.writes, e.reads}) begin
                n_fail++;
                $display("FAIL sd_ld_top%0d: done=%0b fault=%0b lat=%0d wr=%0d rd=%0d, want 1 %0b %0d %0d %0d", i, obs_done, obs_fault, obs_lat, obs_writes, obs_reads, e.fault, e.lat, e.writes, e.reads);
            end
        end
        n_chk++;
        if (obs_data !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL ld_after_sd: data=%h, want 0123456789abcdef", obs_data);
        end
    endtask

    task automatic test_faults();
        logic        sts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s [4] = '{3'd2, 3'd7, 3'd4, 3'd3};
        logic [63:0] ads [4] = '{64'h2000, 64'h10, 64'h10, 64'hFFFF_0000_0000_0000};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, 3'd3, 64'h10, 64'h0);
            void'(sb.pop_front());
            run_req(sts[i], f3s[i], ads[i], 64'h1234);
            e = sb.pop_front();
            n_chk++;
            if ({obs_done, obs_fault, obs_lat, obs_data, obs_writes, obs_reads} !==
                {1'b1, 1'b1, e.lat, 64'h0, 0, 0}) begin
                n_fail++;
                $display("FAIL fault%0d: done=%0b fault=%0b lat=%0d ld=%h wr=%0d rd=%0d, want 1 1 %0d 0 0 0", i, obs_done, obs_fault, obs_lat, obs_data, obs_writes, obs_reads, e.lat);
            end
        end
    endtask

    task automatic test_misalign();
        exp_t e;
        run_req(1'b0, 3'd2, 64'h0E, 64'h0);
        e = sb.pop_front();
        n_chk++;
`ifdef LSU_MISALIGN_FAULT_EN
        if ({obs_done, obs_fault, obs_lat, obs_data} !== {1'b1, 1'b1, 1, 64'h0}) begin
`else
        if ({obs_done, obs_fault, obs_lat, obs_data} !== {1'b1, 1'b0, 2, 64'h0000_0000_0000_A1B2}) begin
`endif
            n_fail++;
            $display("FAIL lw_0x0e: done=%0b fault=%0b lat=%0d data=%h, model %0b %h", obs_done, obs_fault, obs_lat, obs_data, e.fault, e.data);
        end
    endtask

    task automatic test_reset_mid();
        int   wr_seen = 0;
        logic busy_after;
        exp_t e;
        @(negedge clk);
        while (busy) @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'd0; req_addr = 64'h10; req_wdata = 64'h5A; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_chk++;
        if (mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_in_read: mem_read=%0b, want 1", mem_read);
        end
        rst_n = 1'b0;
        #1;
        busy_after = busy;
        repeat (2) begin
            if (mem_write) wr_seen++;
            @(posedge clk); #1;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; if (mem_write) wr_seen++; end
        n_chk++;
        if ({busy_after, wr_seen, mem[2]} !== {1'b0, 0, ref_mem[2]}) begin
            n_fail++;
            $display("FAIL rst_mid_effect: busy=%0b writes=%0d word=%h, want 0 0 %h", busy_after, wr_seen, mem[2], ref_mem[2]);
        end
        run_req(1'b0, 3'd3, 64'h10, 64'h0);
        e = sb.pop_front();
        n_chk++;
        if ({obs_done, obs_data} !== {1'b1, e.data}) begin
            n_fail++;
            $display("FAIL rst_mid_ld: done=%0b data=%h, want 1 %h", obs_done, obs_data, e.data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [63:0] a;
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 64'h2000 + 64'($urandom_range(0, 63)) : 64'($urandom_range(0, 63));
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
            e = sb.pop_front();
            n_chk++;
            if ({obs_done, obs_fault, obs_lat, obs_data, obs_writes, obs_reads, obs_overlap} !==
                {1'b1, e.fault, e.lat, e.data, e.writes, e.reads, 1'b0}) begin
                n_fail++;
                $display("FAIL rand%0d f3=%0d st=%0b a=%h: fault=%0b lat=%0d data=%h wr=%0d rd=%0d, want %0b %0d %h %0d %0d", i, req_funct3, req_store, a, obs_fault, obs_lat, obs_data, obs_writes, obs_reads, e.fault, e.lat, e.data, e.writes, e.reads);
            end
        end
        for (int w = 0; w < 8; w++) begin
            n_chk++;
            if (mem[w] !== ref_mem[w]) begin
                n_fail++;
                $display("FAIL rand_mem[%0d]: %h, want %h", w, mem[w], ref_mem[w]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i] = 64'h0101_0101_0101_0101 * 64'(i) ^ 64'hF0E1_D2C3_B4A5_9687;
            ref_mem[i] = mem[i];
        end
        mem[1] = 64'hA1B2_C3D4_E5F6_0718; ref_mem[1] = mem[1];
        mem[2] = 64'h8877_6655_4433_2211; ref_mem[2] = mem[2];
        #2;
        test_reset();
        test_loads();
        test_misalign();
        test_faults();
        test_stores();
        test_sd_boundary();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
